// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Carries the op encoding, the FSM states and the iteration count.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OpMult  = 3'd0,
        OpMultu = 3'd1,
        OpDiv   = 3'd2,
        OpDivu  = 3'd3,
        OpMthi  = 3'd4,
        OpMtlo  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } muldiv_state_t;

    localparam int unsigned MULDIV_ITERS = 32;
    localparam int unsigned CNT_W        = $clog2(MULDIV_ITERS);
    localparam logic [31:0] DIV0_LO      = 32'hFFFF_FFFF;

    // Ops 0..3 go through the iterative datapath; 4..7 do not.
    function automatic logic is_muldiv(input logic [2:0] op);
        return op[2] == 1'b0;
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the execute stage and the HI/LO unit.
interface hilo_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_content;
    logic [WIDTH-1:0] rt_content;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_content, rt_content,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_content, rt_content,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_unit_iter_core.sv
// One radix-2 step per enable: shift-add multiply or restoring divide.
// acc holds {upper/remainder, lower/quotient}; operands arrive already sign-stripped.
module muldiv_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;

    // Multiply: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // Divide: partial remainder after the left shift may need one extra bit.
    assign div_part = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_part - {1'b0, opnd_q};

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (load_i) begin
            acc_d  = {{WIDTH{1'b0}}, opa_i};
            opnd_d = opb_i;
        end else if (step_i) begin
            if (!is_div_i) begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end else if (div_part >= {1'b0, opnd_q}) begin
                acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Sequential producer of the architectural HI/LO registers: FSM, sign
// handling and HI/LO storage around the iterative datapath.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    hilo_muldiv_unit_if.slave  bus
);

    muldiv_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               dvd_neg_q, dvd_neg_d;
    logic               div_zero_q, div_zero_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               core_load, core_step;
    logic               is_signed;
    logic [WIDTH-1:0]   rs, rt, opa, opb;
    logic [2*WIDTH-1:0] acc, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign rs        = bus.rs_content;
    assign rt        = bus.rt_content;
    assign is_signed = (bus.op == OpMult) || (bus.op == OpDiv);
    assign opa       = (is_signed && rs[WIDTH-1]) ? -rs : rs;
    assign opb       = (is_signed && rt[WIDTH-1]) ? -rt : rt;

    // Truncating division: remainder follows the dividend's sign.
    assign prod_fix = neg_res_q ? -acc : acc;
    assign quot_fix = neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = dvd_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    muldiv_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load_i   (core_load),
        .step_i   (core_step),
        .is_div_i (is_div_q),
        .opa_i    (opa),
        .opb_i    (opb),
        .acc_o    (acc)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        dvd_neg_d  = dvd_neg_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        core_load  = 1'b0;
        core_step  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (is_muldiv(bus.op)) begin
                        core_load  = 1'b1;
                        is_div_d   = bus.op[1];
                        neg_res_d  = is_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
                        dvd_neg_d  = is_signed && rs[WIDTH-1];
                        div_zero_d = (rt == '0);
                        cnt_d      = '0;
                        state_d    = StCalc;
                    end else if (bus.op == OpMthi) begin
                        hi_d   = rs;
                        done_d = 1'b1;
                    end else if (bus.op == OpMtlo) begin
                        lo_d   = rs;
                        done_d = 1'b1;
                    end
                end
            end
            StCalc: begin
                core_step = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MULDIV_ITERS - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (is_div_q) begin
                    // Divide by zero leaves the dividend in HI via the sign fix-up.
                    lo_d = div_zero_q ? WIDTH'(DIV0_LO) : quot_fix;
                    hi_d = rem_fix;
                end else begin
                    lo_d = prod_fix[WIDTH-1:0];
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            dvd_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            dvd_neg_q  <= dvd_neg_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: hand-computed HI/LO results,
// latency, request filtering and mid-operation reset.
module tb_hilo_muldiv_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hilo_muldiv_unit_if #(.WIDTH(32)) bus ();

    hilo_muldiv_unit #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string tag);
        logic [31:0] hi0;
        logic [31:0] lo0;
        int          lat;
        hi0 = bus.hi;
        lo0 = bus.lo;
        bus.start      = 1'b1;
        bus.op         = o;
        bus.rs_content = a;
        bus.rt_content = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, ".busy_after_accept"}, 64'(bus.busy), 64'd1);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 16) begin
                check({tag, ".hi_hold"}, 64'(bus.hi), 64'(hi0));
                check({tag, ".lo_hold"}, 64'(bus.lo), 64'(lo0));
            end
        end
        check({tag, ".latency"}, 64'(lat), 64'd33);
        check({tag, ".hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, ".lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        check({tag, ".done_single"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int lat;
        bus.start      = 1'b0;
        bus.op         = 3'd0;
        bus.rs_content = '0;
        bus.rt_content = '0;
        reset          = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.hi", 64'(bus.hi), 64'd0);
        check("reset.lo", 64'(bus.lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg");
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min");
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        run_op(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, "divu_7_2");
        run_op(3'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, "divu_zero");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");

        // MULTU 3x4 with a DIVU pulsed while busy, then MTHI in the done cycle.
        bus.start      = 1'b1;
        bus.op         = 3'd1;
        bus.rs_content = 32'd3;
        bus.rt_content = 32'd4;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin
                bus.start      = 1'b1;
                bus.op         = 3'd3;
                bus.rs_content = 32'd100;
                bus.rt_content = 32'd7;
            end else begin
                bus.start = 1'b0;
            end
        end
        check("b2b.latency", 64'(lat), 64'd33);
        check("b2b.hi", 64'(bus.hi), 64'd0);
        check("b2b.lo", 64'(bus.lo), 64'd12);
        bus.start      = 1'b1;
        bus.op         = 3'd4;
        bus.rs_content = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("mthi.hi", 64'(bus.hi), 64'h0000_0000_DEAD_BEEF);
        check("mthi.lo", 64'(bus.lo), 64'd12);
        check("mthi.done", 64'(bus.done), 64'd1);
        check("mthi.busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("mthi.done_single", 64'(bus.done), 64'd0);
        check("mthi.busy_after", 64'(bus.busy), 64'd0);

        // Op 6 must be ignored entirely.
        bus.start      = 1'b1;
        bus.op         = 3'd6;
        bus.rs_content = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("op6.busy", 64'(bus.busy), 64'd0);
        check("op6.done", 64'(bus.done), 64'd0);
        check("op6.hi", 64'(bus.hi), 64'h0000_0000_DEAD_BEEF);
        check("op6.lo", 64'(bus.lo), 64'd12);

        // DIV aborted by reset after iteration 10.
        bus.start      = 1'b1;
        bus.op         = 3'd2;
        bus.rs_content = 32'hFFFF_FF9C;
        bus.rt_content = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort.busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort.hi", 64'(bus.hi), 64'd0);
        check("abort.lo", 64'(bus.lo), 64'd0);
        check("abort.busy", 64'(bus.busy), 64'd0);
        check("abort.done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort.no_done", 64'(bus.done), 64'd0);
        run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "divu_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Multi-cycle multiply/divide unit that owns the architectural HI/LO registers. It consumes MULT, MULTU, DIV, DIVU, MTHI and MTLO requests from the execute stage and keeps HI/LO readable for MFHI/MFLO. The combinational ALU still handles all single-cycle operations; this block is the sequential producer of HI/LO.

## Interface
Parameters:
- `WIDTH`, 32: operand width; the design is verified only at 32.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request valid; sampled only when `busy`=0
- `op`  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are ignored
- `rs_content`  in  WIDTH  dividend / multiplicand / MTHI-MTLO source
- `rt_content`  in  WIDTH  divisor / multiplier
- `busy`  out  1  high while an operation is in flight
- `done`  out  1  one-cycle pulse in the cycle new HI/LO are first visible
- `hi`  out  WIDTH  architectural HI register
- `lo`  out  WIDTH  architectural LO register

## Operation
- States:
  - IDLE: accept requests.
  - CALC: 32 radix-2 iterations, driven by a 5-bit counter.
  - FIX: sign correction and HI/LO write.
- IDLE with `start` and `op` in 0..3:
  - Latch absolute values of operands for signed ops; latch raw operands for unsigned ops.
  - Latch a negate-result flag and a dividend-sign flag.
  - Go to CALC.
- Multiply iteration: shift-add into a 64-bit accumulator.
- Divide iteration: restoring division, producing 32-bit quotient and remainder.
- FIX:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient is negative iff the operand signs differ; remainder takes the dividend's sign (truncation toward zero).
  - Write HI = upper/remainder, LO = lower/quotient. Assert `done`. Return to IDLE.
- Divide by zero (DIV and DIVU): LO=0xFFFFFFFF, HI=rs_content as latched. No exception.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. Wrap-around, no trap.
- MTHI/MTLO in IDLE:
  - Write `hi` or `lo` = rs_content at that edge.
  - `done` pulses the next cycle; `busy` stays 0.
- Requests:
  - `start` while `busy`=1 is ignored. No queue; the pipeline holds the request.
  - `start` with `op` 6 or 7 is ignored.
- The pipeline must stall MFHI/MFLO and a new MULT/DIV/MTHI/MTLO while `busy`=1.
- `hi`/`lo` hold their values throughout CALC and change only in FIX or on MTHI/MTLO.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- Reset mid-operation aborts. The next cycle shows the reset values and no `done` pulse.
- Mult/div latency, with the start-accept edge as E0:
  - CALC iterations occur at E1..E32.
  - FIX executes at E33.
  - After E33: new `hi`/`lo` visible, `done`=1, `busy`=0.
- `busy` is high from after E0 through the cycle before `done`.
- Back-to-back: `start` in the `done` cycle is accepted, so a new op begins at that edge.
- MTHI/MTLO latency: register updated at E0; `done` high in the cycle after E0.
- `done` is registered, never combinational from `start`.

## Structure
- Package `muldiv_pkg`:
  - `muldiv_op_t` enum for the `op` encoding.
  - `muldiv_state_t` (IDLE, CALC, FIX).
  - `MULDIV_ITERS`=32.
  - Divide-by-zero LO constant 0xFFFFFFFF.
- One sub-module is natural: `muldiv_iter_core`.
  - Holds the 64-bit accumulator/remainder register and performs one shift-add or restore-subtract step per enable.
  - The top level keeps the FSM, sign handling and HI/LO registers.
- Expected size: ~200 lines of RTL.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` exactly 33 cycles after the accept edge, single pulse.
- MULT 0xFFFFFFFD × 0x00000005 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 / 0x00000002 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 → LO=3, HI=1.
- DIVU 0x00001234 / 0 → LO=0xFFFFFFFF, HI=0x00001234; DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Start MULTU 3×4, pulse `start` DIVU at cycle 5 (ignored), then MTHI 0xDEADBEEF in the `done` cycle:
  - First result HI=0, LO=12.
  - Then `hi`=0xDEADBEEF with `lo` unchanged, `done` pulse, `busy` stays 0.
- DIV in flight, assert `reset` at iteration 10 → next cycle `hi`=`lo`=0, `busy`=0, no `done`; a following DIVU 100/7 → LO=14, HI=2.
